// File: rtl/prach_nco_pkg.sv
// Shared constants, quadrant type and elaboration-time helpers for prach_nco.
package prach_nco_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam real HALF_PI = 1.5707963267948966;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // round(amp * sin(pi/2 * j / 2^aw)); a Taylor series keeps it free of math-library calls
    function automatic int tab_entry(input int unsigned j, input int unsigned aw,
                                     input int unsigned amp);
        real x, term, s;
        x = HALF_PI * real'(j) / real'(1 << aw);
        term = x;
        s = x;
        for (int unsigned n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s = s + term;
        end
        return $rtoi(real'(amp) * s + 0.5);
    endfunction

endpackage

// File: rtl/prach_nco_rom.sv
// Dual-read registered quarter-wave sine table, depth 2^LUT_AW + 1, built at elaboration.
module prach_nco_rom
    import prach_nco_pkg::*;
#(
    parameter int unsigned LUT_AW    = 10,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned AMPLITUDE = 16383
) (
    input  logic                 clk,
    input  logic [LUT_AW:0]      addr_a,
    input  logic [LUT_AW:0]      addr_b,
    output logic [OUT_WIDTH-1:0] data_a,
    output logic [OUT_WIDTH-1:0] data_b
);

    localparam int unsigned N = 1 << LUT_AW;

    logic [OUT_WIDTH-1:0] tab [0:N];

    for (genvar j = 0; j <= N; j++) begin : g_tab
        localparam int V = tab_entry(j, LUT_AW, AMPLITUDE);
        assign tab[j] = OUT_WIDTH'(V);
    end

    always_ff @(posedge clk) begin
        data_a <= tab[addr_a];
        data_b <= tab[addr_b];
    end

endmodule

// File: rtl/prach_nco.sv
// PRACH frequency-shift NCO: phasor generator plus matched I/Q delay, 4-cycle latency.
// Optional phase dither enabled by defining PRACH_NCO_DITHER_EN.
module prach_nco
    import prach_nco_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned LUT_AW      = 10,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned AMPLITUDE   = 16383
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw,
    input  logic [PHASE_WIDTH-1:0] cfg_phase,
    input  logic                   in_sync,
    input  logic                   in_valid,
    input  logic [OUT_WIDTH-1:0]   in_i,
    input  logic [OUT_WIDTH-1:0]   in_q,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_i,
    output logic [OUT_WIDTH-1:0]   out_q,
    output logic [OUT_WIDTH-1:0]   out_cos,
    output logic [OUT_WIDTH-1:0]   out_sin
);

    localparam int unsigned N    = 1 << LUT_AW;
    localparam int unsigned TW   = LUT_AW + 2;
    localparam int unsigned DISC = PHASE_WIDTH - TW;

    // S1: accumulator and phase register
    logic [PHASE_WIDTH-1:0] acc, fcw_reg, phase_reg;
    logic                   v1;
    logic [OUT_WIDTH-1:0]   i1, q1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            fcw_reg   <= '0;
            phase_reg <= '0;
            v1        <= 1'b0;
            i1        <= '0;
            q1        <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                i1 <= in_i;
                q1 <= in_q;
                if (in_sync) begin
                    fcw_reg   <= cfg_fcw;
                    phase_reg <= cfg_phase;
                    acc       <= cfg_phase + cfg_fcw;
                end else begin
                    phase_reg <= acc;
                    acc       <= acc + fcw_reg;
                end
            end
        end
    end

    logic [PHASE_WIDTH-1:0] phase_d;

`ifdef PRACH_NCO_DITHER_EN
    localparam int unsigned DW = (DISC < 16) ? DISC : 16;

    logic [15:0] lfsr, dith1;

    // dith1 travels alongside phase_reg so each sample sees its own LFSR value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr  <= LFSR_SEED;
            dith1 <= '0;
        end else if (in_valid) begin
            dith1 <= in_sync ? LFSR_SEED : lfsr;
            lfsr  <= lfsr_step(in_sync ? LFSR_SEED : lfsr);
        end
    end

    assign phase_d = phase_reg + (PHASE_WIDTH'(dith1[DW-1:0]) << (DISC - DW));
`else
    assign phase_d = phase_reg;
`endif

    // S2: truncation and quadrant/address decode
    logic [TW-1:0]        trunc;
    quad_t                quad2, quad3;
    logic [LUT_AW-1:0]    k2;
    logic                 v2, v3;
    logic [OUT_WIDTH-1:0] i2, q2, i3, q3;

    assign trunc = TW'(phase_d >> DISC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quad2 <= Q0;
            k2    <= '0;
            v2    <= 1'b0;
            i2    <= '0;
            q2    <= '0;
            quad3 <= Q0;
            v3    <= 1'b0;
            i3    <= '0;
            q3    <= '0;
        end else begin
            quad2 <= quad_t'(trunc[TW-1 -: 2]);
            k2    <= trunc[LUT_AW-1:0];
            v2    <= v1;
            i2    <= i1;
            q2    <= q1;
            quad3 <= quad2;
            v3    <= v2;
            i3    <= i2;
            q3    <= q2;
        end
    end

    // S3: registered table read at k and N-k
    logic [OUT_WIDTH-1:0] tk, tnk;

    prach_nco_rom #(
        .LUT_AW    (LUT_AW),
        .OUT_WIDTH (OUT_WIDTH),
        .AMPLITUDE (AMPLITUDE)
    ) u_rom (
        .clk    (clk),
        .addr_a ({1'b0, k2}),
        .addr_b ((LUT_AW + 1)'(N) - {1'b0, k2}),
        .data_a (tk),
        .data_b (tnk)
    );

    // S4: sign/swap mux into output registers
    logic [OUT_WIDTH-1:0] cos_n, sin_n;

    always_comb begin
        cos_n = tnk;
        sin_n = tk;
        case (quad3)
            Q1: begin cos_n = -tk;  sin_n = tnk; end
            Q2: begin cos_n = -tnk; sin_n = -tk; end
            Q3: begin cos_n = tk;   sin_n = -tnk; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_cos   <= '0;
            out_sin   <= '0;
        end else begin
            out_valid <= v3;
            out_i     <= i3;
            out_q     <= q3;
            out_cos   <= cos_n;
            out_sin   <= sin_n;
        end
    end

endmodule

// File: tb/tb_prach_nco.sv
// Scoreboard bench for prach_nco (default build): trig reference model, randomized and directed stimulus.
module tb_prach_nco;

    localparam int AMP = 16383;
    localparam real TWO_PI = 6.283185307179586;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_fcw, cfg_phase;
    logic        in_sync, in_valid;
    logic [15:0] in_i, in_q;
    logic        out_valid;
    logic [15:0] out_i, out_q, out_cos, out_sin;

    always #5 clk = ~clk;

    prach_nco #(
        .PHASE_WIDTH (32),
        .LUT_AW      (10),
        .OUT_WIDTH   (16),
        .AMPLITUDE   (AMP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_fcw   (cfg_fcw),
        .cfg_phase (cfg_phase),
        .in_sync   (in_sync),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_cos   (out_cos),
        .out_sin   (out_sin)
    );

    typedef struct {
        int unsigned due;
        logic [15:0] i, q, c, s;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;

    // reference model state
    logic [31:0] m_acc = '0, m_fcw = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rnd(input real v);
        int r;
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return 16'(r);
    endfunction

    // phasor at the 12-bit truncated phase, straight from cos/sin
    function automatic void phasor(input logic [31:0] ph, output logic [15:0] c, output logic [15:0] s);
        int unsigned idx;
        real ang;
        idx = ph >> 20;
        ang = TWO_PI * real'(idx) / 4096.0;
        c = rnd(real'(AMP) * $cos(ang));
        s = rnd(real'(AMP) * $sin(ang));
    endfunction

    task automatic step(input bit v, input bit s, input logic [31:0] f, input logic [31:0] p);
        exp_t e;
        logic [31:0] ph;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        in_valid  = v;
        in_sync   = s;
        cfg_fcw   = f;
        cfg_phase = p;
        in_i      = 16'($urandom);
        in_q      = 16'($urandom);
        if (v) begin
            if (s) begin
                ph    = p;
                m_fcw = f;
                m_acc = p + f;
            end else begin
                ph    = m_acc;
                m_acc = m_acc + m_fcw;
            end
            e.due = cyc + 4;
            e.i   = in_i;
            e.q   = in_q;
            phasor(ph, e.c, e.s);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sync  = 1'b1;
        in_i     = 16'($urandom);
        in_q     = 16'($urandom);
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        m_acc = '0;
        m_fcw = '0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing output due cycle %0d (now %0d)", e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (out_valid !== 1'b1 || out_i !== e.i || out_q !== e.q ||
                    out_cos !== e.c || out_sin !== e.s) begin
                    miscompares++;
                    $display("FAIL sample cyc %0d: got v=%b i=%0d q=%0d cos=%0d sin=%0d, expected v=1 i=%0d q=%0d cos=%0d sin=%0d",
                             cyc, out_valid, $signed(out_i), $signed(out_q), $signed(out_cos), $signed(out_sin),
                             $signed(e.i), $signed(e.q), $signed(e.c), $signed(e.s));
                end
            end else if (out_valid !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious out_valid at cyc %0d: got %b, expected 0", cyc, out_valid);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0;
        cfg_fcw = '0; cfg_phase = '0; in_i = '0; in_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset out_i", out_i, 16'd0);
        chk("reset out_q", out_q, 16'd0);
        chk("reset out_cos", out_cos, 16'd0);
        chk("reset out_sin", out_sin, 16'd0);
        mon_en = 1'b1;

        // constant phasor
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 32'd0, 32'd0);
        repeat (3) step(1'b0, 1'b0, '0, '0);
        // quarter-turn steps, continuous then gapped
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 32'h4000_0000, 32'd0);
        for (int i = 0; i < 24; i++) step(i % 3 == 0, i == 0, 32'h4000_0000, 32'd0);
        // half-turn start, then config changes without sync are ignored
        step(1'b1, 1'b1, 32'h4000_0000, 32'h8000_0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, $urandom);
        // three-quarter steps across accumulator wraps
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 32'hC000_0000, 32'd0);
        // reset mid-stream, then resume without sync
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 32'h4000_0000, 32'd0);
        pulse_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, $urandom);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [31:0] f, p;
            r = $urandom_range(0, 99);
            f = $urandom_range(0, 1) ? ($urandom & 32'hFFF0_0000) : $urandom;
            p = $urandom_range(0, 1) ? ($urandom & 32'hFFF0_0000) : $urandom;
            if (r < 1) pulse_reset();
            else step(r < 75, r < 8, f, p);
        end

        repeat (8) step(1'b0, 1'b0, '0, '0);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d outputs outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prach_nco.md
# prach_nco

Numerically controlled oscillator for frequency shift in the PRACH long-format receive path. It produces the unit phasor (cos, sin) that feeds the B operand of the downstream complex multiplier. It also passes the I/Q sample stream through on a matched delay, so A and B reach the multiplier on the same cycle. The phase accumulator advances only on valid samples and restarts on a per-occasion sync pulse.

## Interface

- PHASE_WIDTH, 32, phase accumulator width; one full turn = 2^PHASE_WIDTH
- LUT_AW, 10, quarter-wave table address bits (N = 2^LUT_AW)
- OUT_WIDTH, 16, width of cos/sin and I/Q data
- AMPLITUDE, 16383, full-scale phasor magnitude (Q1.14, matching multiplier SHIFT = 14)

Ports:

- clk  in  1  clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_fcw  in  PHASE_WIDTH  frequency control word, unsigned, modulo 2^PHASE_WIDTH
- cfg_phase  in  PHASE_WIDTH  initial phase offset
- in_sync  in  1  first sample of an occasion; qualified by in_valid
- in_valid  in  1  sample strobe; no backpressure
- in_i, in_q  in  OUT_WIDTH each  input sample, signed
- out_valid  out  1  output strobe
- out_i, out_q  out  OUT_WIDTH each  delayed sample, to multiplier A
- out_cos, out_sin  out  OUT_WIDTH each  phasor, signed two's complement, to multiplier B

## Operation

- Register configuration: cfg_fcw and cfg_phase are captured into internal registers only when in_sync && in_valid. Changing them at any other time has no effect.
- Phase on a sync sample: phase = cfg_phase. The accumulator is loaded with cfg_phase + cfg_fcw.
- Phase on any other valid sample: phase = acc, then acc <= acc + fcw_reg. Arithmetic wraps modulo 2^PHASE_WIDTH.
- Invalid cycles: acc is held and nothing enters the pipeline.
- Truncation: the top LUT_AW+2 bits of phase are kept. The top 2 bits give quadrant q; the next LUT_AW bits give k.
- Quarter-wave table: depth N+1. tab[j] = round(AMPLITUDE·sin(π/2·j/N)), so tab[0] = 0 and tab[N] = AMPLITUDE.
- Quadrant mapping:
  - q0: cos = tab[N-k], sin = tab[k]
  - q1: cos = -tab[k], sin = tab[N-k]
  - q2: cos = -tab[N-k], sin = -tab[k]
  - q3: cos = tab[k], sin = -tab[N-k]
- Overflow: |output| ≤ AMPLITUDE < 2^(OUT_WIDTH-1), so negation never overflows and no saturation logic is needed.
- I/Q path: a pure delay; values are unmodified.

## Timing

- Latency: 4 cycles from in_valid to out_valid, fixed, with no bubbles added or removed.
- Pipeline stages:
  - S1: phase register.
  - S2: dither add, quadrant/address decode.
  - S3: registered ROM read (two ports: k and N-k).
  - S4: sign/swap mux into the output registers.
- Valid gaps: the valid pattern on the output equals the input pattern delayed by 4. Gaps do not disturb the phase sequence.
- Sync and valid together: that sample's output uses cfg_phase exactly.
- Reset values: acc = 0; fcw_reg = 0; phase_reg = 0; the whole valid pipe = 0; out_* = 0; LFSR = 16'hACE1.
- Reset mid-stream: samples in flight are discarded. out_valid is low from the cycle after rst_n is sampled low. After release, phase resumes from acc = 0 with fcw = 0 until the next sync.

## Configuration

- PRACH_NCO_DITHER_EN defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1) advances once per valid sample.
  - Its low min(16, PHASE_WIDTH-LUT_AW-2) bits are added to the discarded phase bits before truncation. This spreads phase-truncation spurs.
  - The LFSR is reseeded on sync.
- Not defined: plain truncation, no LFSR; the output is bit-exact deterministic.
- Effect at exact table points: a phase whose discarded bits are zero yields identical results in both builds.

## Structure

- Package prach_nco_pkg holds:
  - the LFSR seed and tap mask constants;
  - a quadrant typedef (2-bit enum Q0..Q3);
  - a constant function that computes table entries at elaboration.
- Sub-module prach_nco_rom: dual-read, registered quarter-wave table, parameterised by LUT_AW and OUT_WIDTH.
- Top level: accumulator, dither, pipeline registers, quadrant mux, and data delay line.

## Test plan

- fcw = 0, phase = 0, sync on first of 8 continuous valid samples → cos = 16383, sin = 0 on every output; out_valid first high 4 cycles after in_valid.
- fcw = 2^30 (quarter turn), sync → (cos, sin) repeats (16383, 0), (0, 16383), (-16383, 0), (0, -16383); out_i/out_q equal the inputs from 4 cycles earlier.
- Same stimulus with in_valid toggling 1,0,0,1,… → the same phasor sequence; the out_valid pattern is the input pattern shifted by 4.
- cfg_phase = 2^31 with sync, then cfg_fcw/cfg_phase changed without sync → first output (-16383, 0); later outputs keep following the old fcw.
- fcw = 2^31 + 2^30 running across an accumulator wrap → sequence (16383, 0), (0, -16383), (-16383, 0), (0, 16383) with no glitch at the wrap.
- rst_n low for 1 cycle mid-stream → out_valid low from the next cycle; in-flight samples are lost; after release, outputs are (16383, 0) until a new sync.
